missile_ctl: RTL and testbench
==============================

# missile_ctl

Sequencing controller for the player ship's missile. It turns a fire button into a single in-flight missile: launch from the ship position, per-frame upward motion, removal at the screen top or on hit, then a cooldown before the next shot. It sits upstream of the missile renderer and drives its `xpos`/`ypos`/`on` inputs. Frame timing comes from the same `vblnk` stream that runs through the drawing pipeline.

## Interface
Parameters:
- `SPEED`, 8: pixels the missile rises per frame; 11-bit.
- `MISSILE_HEIGHT`, 20: vertical launch offset above the ship top edge.
- `COOLDOWN_FRAMES`, 10: frames in COOL before a new shot is accepted; counter is 8 bits, range 0–255.

Ports:
- `pclk`, in, 1: pixel clock; all logic on its rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `fire`, in, 1: fire button, level; only rising edges act.
- `ship_xpos`, in, 11: ship left edge.
- `ship_ypos`, in, 11: ship top edge.
- `vblnk_in`, in, 1: vertical blank; its rising edge is the frame tick.
- `hit`, in, 1: collision pulse or level; meaningful only in FLY.
- `xpos`, out, 11: missile x, registered.
- `ypos`, out, 11: missile y, registered.
- `on`, out, 1: missile visible, registered.
- `busy`, out, 1: 1 whenever state is not IDLE.
- `shot`, out, 1: one-cycle pulse on launch.

## Operation
Edge detection:
- `fire_d` and `vblnk_d` are 1-cycle delayed copies.
- `fire_edge = fire & ~fire_d`.
- `tick = vblnk_in & ~vblnk_d`.

FSM has three states: IDLE, FLY, COOL.

IDLE:
- `on` = 0.
- On `fire_edge`:
  - `xpos` <= `ship_xpos`.
  - `ypos` <= `ship_ypos - MISSILE_HEIGHT`, saturating to 0 if `ship_ypos < MISSILE_HEIGHT`.
  - `on` <= 1, `shot` <= 1, go to FLY.

FLY:
- Priority is `hit` first, then `tick`.
- `hit` = 1: `on` <= 0, `cnt` <= `COOLDOWN_FRAMES`, go to COOL. `ypos` holds.
- Else on `tick`:
  - If `ypos < SPEED`: `ypos` <= 0, `on` <= 0, `cnt` <= `COOLDOWN_FRAMES`, go to COOL.
  - Otherwise: `ypos` <= `ypos - SPEED`.
- `xpos` is fixed for the whole flight and does not track the ship.

COOL:
- On `tick` with `cnt != 0`: `cnt` <= `cnt - 1`.
- When `cnt == 0` (tick or not): go to IDLE next cycle.
- Result: COOL lasts exactly `COOLDOWN_FRAMES` ticks plus 1 cycle. With `COOLDOWN_FRAMES` = 0 it exits after 1 cycle.

Boundary rules:
- `fire_edge` in FLY or COOL is discarded, never queued. A button held through COOL does not fire on return to IDLE; a new press is required.
- `hit` outside FLY is ignored.
- `fire_d`/`vblnk_d` update every cycle in all states.
- All subtraction is unsigned 11-bit, guarded by the compares above. No wrap-around is permitted.

## Timing
- Reset values: state IDLE, `xpos` 0, `ypos` 0, `on` 0, `busy` 0, `shot` 0, `cnt` 0, `fire_d` 0, `vblnk_d` 0.
- If `vblnk_in` is 1 in the first cycle after reset, a tick is registered. This is harmless in IDLE.
- Reset mid-flight or in COOL: all outputs return to reset values the next cycle. No partial state survives.
- Launch latency: `fire` rises at cycle N; `on`/`xpos`/`ypos`/`shot` are valid at N+1. `shot` is high for exactly one cycle.
- Motion latency: tick at cycle N; new `ypos` is visible at N+1. Exactly one update per frame.
- Hit latency: `hit` at N; `on` = 0 at N+1.
- `busy` is registered with state: 1 from the launch cycle+1 until the cycle after COOL exits.
- Outputs change only at the vblank edge (motion) or on fire/hit events, so the renderer sees a stable position across the active area.

## Test plan
- Launch (SPEED 8, HEIGHT 20, COOLDOWN 3), `ship_xpos` 400, `ship_ypos` 700, pulse `fire` -> next cycle `on` 1, `xpos` 400, `ypos` 680, `shot` 1 for one cycle. After 5 ticks -> `ypos` 640.
- Top exit: fly until `ypos` 8, tick -> `ypos` 0, `on` 1. Next tick -> `on` 0, COOL. 3 ticks later plus 1 cycle -> `busy` 0.
- Hit and tick in the same cycle at `ypos` 300 -> `on` 0, `ypos` 300, COOL entered, no decrement applied.
- Fire edges during FLY and COOL plus `fire` held high into IDLE -> no launch, `shot` stays 0. Release and re-press -> launch.
- `ship_ypos` 10 -> launch `ypos` 0. Next tick -> `on` 0.
- `rst` asserted mid-flight at `ypos` 500 -> next cycle all outputs 0, state IDLE. An immediate `fire` edge launches normally.

Source files
------------

// File: rtl/missile_ctl.sv
// Player missile sequencer: fire-edge launch, per-frame climb, removal at the
// screen top or on hit, then a frame-counted cooldown before the next shot.
module missile_ctl #(
  parameter int unsigned SPEED           = 8,
  parameter int unsigned MISSILE_HEIGHT  = 20,
  parameter int unsigned COOLDOWN_FRAMES = 10
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        fire,
  input  logic [10:0] ship_xpos,
  input  logic [10:0] ship_ypos,
  input  logic        vblnk_in,
  input  logic        hit,
  output logic [10:0] xpos,
  output logic [10:0] ypos,
  output logic        on,
  output logic        busy,
  output logic        shot
);

  localparam logic [10:0] SPEED_W  = 11'(SPEED);
  localparam logic [10:0] HEIGHT_W = 11'(MISSILE_HEIGHT);
  localparam logic [7:0]  COOL_W   = 8'(COOLDOWN_FRAMES);

  typedef enum logic [1:0] {IDLE, FLY, COOL} state_t;

  state_t     state;
  logic [7:0] cnt;
  logic       fire_d;
  logic       vblnk_d;
  logic       fire_edge;
  logic       tick;

  assign fire_edge = fire & ~fire_d;
  assign tick      = vblnk_in & ~vblnk_d;

  always_ff @(posedge pclk) begin
    if (rst) begin
      state   <= IDLE;
      xpos    <= '0;
      ypos    <= '0;
      on      <= 1'b0;
      busy    <= 1'b0;
      shot    <= 1'b0;
      cnt     <= '0;
      fire_d  <= 1'b0;
      vblnk_d <= 1'b0;
    end else begin
      fire_d  <= fire;
      vblnk_d <= vblnk_in;
      shot    <= 1'b0;
      case (state)
        IDLE: begin
          on   <= 1'b0;
          busy <= 1'b0;
          if (fire_edge) begin
            xpos  <= ship_xpos;
            ypos  <= (ship_ypos < HEIGHT_W) ? '0 : ship_ypos - HEIGHT_W;
            on    <= 1'b1;
            shot  <= 1'b1;
            busy  <= 1'b1;
            state <= FLY;
          end
        end
        FLY: begin
          busy <= 1'b1;
          // hit outranks the frame tick; ypos freezes where the hit landed
          if (hit) begin
            on    <= 1'b0;
            cnt   <= COOL_W;
            state <= COOL;
          end else if (tick) begin
            if (ypos < SPEED_W) begin
              ypos  <= '0;
              on    <= 1'b0;
              cnt   <= COOL_W;
              state <= COOL;
            end else begin
              ypos <= ypos - SPEED_W;
            end
          end
        end
        COOL: begin
          if (cnt == '0) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            busy <= 1'b1;
            if (tick) cnt <= cnt - 8'd1;
          end
        end
        default: begin
          busy  <= 1'b0;
          on    <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_missile_ctl.sv
// Bench for missile_ctl: directed scenarios plus randomized traffic, checked
// against an event-level missile model kept in the bench.
module tb_missile_ctl;

  localparam int SPD = 8;
  localparam int HGT = 20;
  localparam int CDF = 3;

  logic        pclk = 1'b0;
  logic        rst = 1'b1;
  logic        fire = 1'b0;
  logic [10:0] ship_xpos = '0;
  logic [10:0] ship_ypos = '0;
  logic        vblnk_in = 1'b0;
  logic        hit = 1'b0;
  logic [10:0] xpos;
  logic [10:0] ypos;
  logic        on;
  logic        busy;
  logic        shot;

  int n_cmp = 0;
  int n_bad = 0;

  missile_ctl #(.SPEED(SPD), .MISSILE_HEIGHT(HGT), .COOLDOWN_FRAMES(CDF)) dut (
    .pclk(pclk), .rst(rst), .fire(fire), .ship_xpos(ship_xpos),
    .ship_ypos(ship_ypos), .vblnk_in(vblnk_in), .hit(hit),
    .xpos(xpos), .ypos(ypos), .on(on), .busy(busy), .shot(shot)
  );

  always #5 pclk = ~pclk;

  // Reference: a missile is either airborne, cooling down for a number of
  // frames, or absent. Button/frame edges are found from the previous sample.
  bit prev_fire = 0, prev_vb = 0;
  bit m_alive = 0, m_cooling = 0, m_on = 0, m_shot = 0;
  int m_frames = 0;
  int m_x = 0, m_y = 0;

  always @(posedge pclk) begin
    bit pressed, frame;
    if (rst) begin
      prev_fire = 0; prev_vb = 0; m_alive = 0; m_cooling = 0;
      m_on = 0; m_shot = 0; m_frames = 0; m_x = 0; m_y = 0;
    end else begin
      pressed = fire && !prev_fire;
      frame   = vblnk_in && !prev_vb;
      prev_fire = fire;
      prev_vb   = vblnk_in;
      m_shot = 0;
      if (m_alive) begin
        if (hit) begin
          m_alive = 0; m_on = 0; m_cooling = 1; m_frames = CDF;
        end else if (frame) begin
          if (m_y - SPD < 0) begin
            m_y = 0; m_alive = 0; m_on = 0; m_cooling = 1; m_frames = CDF;
          end else m_y = m_y - SPD;
        end
      end else if (m_cooling) begin
        if (m_frames == 0) m_cooling = 0;
        else if (frame) m_frames = m_frames - 1;
      end else if (pressed) begin
        m_x = int'(ship_xpos);
        m_y = (int'(ship_ypos) > HGT) ? int'(ship_ypos) - HGT : 0;
        m_on = 1; m_shot = 1; m_alive = 1;
      end
    end
  end

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic frame_tick(input int low_cycles);
    vblnk_in = 1'b1;
    step();
    vblnk_in = 1'b0;
    for (int i = 0; i < low_cycles; i++) step();
  endtask

  task automatic test_reset();
    rst = 1'b1; vblnk_in = 1'b1;
    step(); step();
    n_cmp++;
    if ({on, busy, shot, xpos, ypos} !== 25'd0) begin
      n_bad++;
      $display("FAIL reset_outputs got %h required 0", {on, busy, shot, xpos, ypos});
    end
    rst = 1'b0;
    step();
    vblnk_in = 1'b0;
    step();
    n_cmp++;
    if (busy !== 1'b0 || on !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_tick_idle got busy=%b on=%b required 0 0", busy, on);
    end
  endtask

  task automatic test_launch();
    ship_xpos = 11'd400; ship_ypos = 11'd700;
    fire = 1'b1;
    step();
    n_cmp++;
    if ({on, shot, busy, xpos, ypos} !== {3'b111, 11'd400, 11'd680}) begin
      n_bad++;
      $display("FAIL launch got on=%b shot=%b busy=%b x=%0d y=%0d required 1 1 1 400 680",
               on, shot, busy, xpos, ypos);
    end
    fire = 1'b0;
    step();
    n_cmp++;
    if (shot !== 1'b0) begin
      n_bad++;
      $display("FAIL shot_width got %b required 0", shot);
    end
    for (int i = 0; i < 5; i++) frame_tick(2);
    n_cmp++;
    if (ypos !== 11'd640 || on !== 1'b1) begin
      n_bad++;
      $display("FAIL five_ticks got y=%0d on=%b required 640 1", ypos, on);
    end
  endtask

  task automatic test_top_exit();
    int guard = 0;
    while (ypos !== 11'd8 && guard < 200) begin
      frame_tick(1);
      guard++;
    end
    frame_tick(1);
    n_cmp++;
    if (ypos !== 11'd0 || on !== 1'b1) begin
      n_bad++;
      $display("FAIL top_reach_zero got y=%0d on=%b required 0 1", ypos, on);
    end
    frame_tick(1);
    n_cmp++;
    if (on !== 1'b0 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL top_exit got on=%b busy=%b required 0 1", on, busy);
    end
    frame_tick(1);
    frame_tick(1);
    vblnk_in = 1'b1;
    step();
    vblnk_in = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL cool_last_tick got busy=%b required 1", busy);
    end
    step();
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL cool_exit got busy=%b required 0", busy);
    end
  endtask

  task automatic test_hit_tick();
    int cyc = 0;
    ship_xpos = 11'd50; ship_ypos = 11'd320;
    fire = 1'b1; step(); fire = 1'b0; step();
    hit = 1'b1; vblnk_in = 1'b1;
    step();
    hit = 1'b0; vblnk_in = 1'b0;
    n_cmp++;
    if (on !== 1'b0 || ypos !== 11'd300 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL hit_with_tick got on=%b y=%0d busy=%b required 0 300 1", on, ypos, busy);
    end
    // full cooldown still ahead: three more frames plus one cycle
    step();
    frame_tick(1); frame_tick(1);
    vblnk_in = 1'b1; step(); vblnk_in = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL hit_cool_full got busy=%b required 1", busy);
    end
    while (busy === 1'b1 && cyc < 10) begin step(); cyc++; end
    n_cmp++;
    if (cyc !== 1) begin
      n_bad++;
      $display("FAIL hit_cool_len got %0d extra cycles required 1", cyc);
    end
  endtask

  task automatic test_fire_discard();
    bit any_shot = 0;
    ship_xpos = 11'd100; ship_ypos = 11'd400;
    fire = 1'b1; step(); fire = 1'b0; step();
    ship_xpos = 11'd555;
    fire = 1'b1; step();
    n_cmp++;
    if (shot !== 1'b0 || xpos !== 11'd100) begin
      n_bad++;
      $display("FAIL fly_fire got shot=%b x=%0d required 0 100", shot, xpos);
    end
    fire = 1'b0; step();
    frame_tick(1);
    n_cmp++;
    if (ypos !== 11'd372 || xpos !== 11'd100) begin
      n_bad++;
      $display("FAIL fly_xfixed got x=%0d y=%0d required 100 372", xpos, ypos);
    end
    hit = 1'b1; step(); hit = 1'b0;
    fire = 1'b1;
    for (int i = 0; i < 5; i++) begin
      vblnk_in = 1'b1; step(); any_shot |= shot;
      vblnk_in = 1'b0; step(); any_shot |= shot;
    end
    n_cmp++;
    if (any_shot || busy !== 1'b0 || on !== 1'b0) begin
      n_bad++;
      $display("FAIL held_fire got shot_seen=%b busy=%b on=%b required 0 0 0", any_shot, busy, on);
    end
    fire = 1'b0; step();
    fire = 1'b1; step();
    n_cmp++;
    if (shot !== 1'b1 || on !== 1'b1 || xpos !== 11'd555) begin
      n_bad++;
      $display("FAIL repress got shot=%b on=%b x=%0d required 1 1 555", shot, on, xpos);
    end
    fire = 1'b0;
    hit = 1'b1; step(); hit = 1'b0;
    for (int i = 0; i < 4; i++) frame_tick(1);
  endtask

  task automatic test_low_launch();
    ship_ypos = 11'd10;
    fire = 1'b1; step(); fire = 1'b0;
    n_cmp++;
    if (ypos !== 11'd0 || on !== 1'b1) begin
      n_bad++;
      $display("FAIL low_launch got y=%0d on=%b required 0 1", ypos, on);
    end
    step();
    frame_tick(1);
    n_cmp++;
    if (on !== 1'b0 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL low_exit got on=%b busy=%b required 0 1", on, busy);
    end
    for (int i = 0; i < 4; i++) frame_tick(1);
  endtask

  task automatic test_rst_mid();
    ship_xpos = 11'd77; ship_ypos = 11'd520;
    fire = 1'b1; step(); fire = 1'b0; step();
    n_cmp++;
    if (ypos !== 11'd500 || on !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_pre got y=%0d on=%b required 500 1", ypos, on);
    end
    rst = 1'b1; step(); rst = 1'b0;
    n_cmp++;
    if ({on, busy, shot, xpos, ypos} !== 25'd0) begin
      n_bad++;
      $display("FAIL rst_mid got %h required 0", {on, busy, shot, xpos, ypos});
    end
    fire = 1'b1; step(); fire = 1'b0;
    n_cmp++;
    if (on !== 1'b1 || shot !== 1'b1 || ypos !== 11'd500 || xpos !== 11'd77) begin
      n_bad++;
      $display("FAIL rst_relaunch got on=%b shot=%b x=%0d y=%0d required 1 1 77 500",
               on, shot, xpos, ypos);
    end
    step();
  endtask

  task automatic test_random();
    logic [24:0] got, exp;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) fire = ~fire;
      vblnk_in = ($urandom_range(0, 5) == 0);
      hit = ($urandom_range(0, 30) == 0);
      rst = ($urandom_range(0, 700) == 0);
      if ($urandom_range(0, 20) == 0) begin
        ship_xpos = 11'($urandom_range(0, 2047));
        ship_ypos = ($urandom_range(0, 3) == 0) ? 11'($urandom_range(0, 30))
                                                : 11'($urandom_range(0, 2047));
      end
      step();
      got = {on, busy, shot, xpos, ypos};
      exp = {m_on, m_alive | m_cooling, m_shot, 11'(m_x), 11'(m_y)};
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL random_cyc%0d got on/busy/shot/x/y=%b%b%b/%0d/%0d required %b%b%b/%0d/%0d",
                 c, got[24], got[23], got[22], got[21:11], got[10:0],
                 exp[24], exp[23], exp[22], exp[21:11], exp[10:0]);
      end
    end
    rst = 1'b0; fire = 1'b0; hit = 1'b0; vblnk_in = 1'b0;
  endtask

  initial begin
    test_reset();
    test_launch();
    test_top_exit();
    test_hit_tick();
    test_fire_discard();
    test_low_launch();
    test_rst_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
